deck_rng: RTL and testbench
===========================

# deck_rng

Parametrised pseudo-random index generator for the card-game datapath. A free-running Fibonacci LFSR feeds a request/response front end that returns uniformly distributed indices in [0, RANGE) using rejection sampling. An optional no-repeat (deal) mode guarantees each index is issued once per deck, with a bounded-latency fallback. It sits between the game controller (requester) and the card-memory address path.

## Interface
- WIDTH, 16: LFSR width (≥ OUT_W + FIELD_LSB).
- TAPS, 16'hB400: feedback tap mask (bits 15,13,12,10).
- SEED, 16'hACE1: reset seed, and the substitute for a zero seed.
- OUT_W, 6: output index width.
- FIELD_LSB, 5: LSB of the candidate field taken from the LFSR.
- RANGE, 52: number of valid indices; must satisfy 2^(OUT_W-1) ≤ RANGE ≤ 2^OUT_W.
- NO_REPEAT, 1: 1 = deal mode (no repeats until deck_clear), 0 = independent draws.
- MAX_TRIES, 16: consecutive rejections before fallback (≥1).
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- seed_load  in  1  load seed_in into LFSR.
- seed_in  in  WIDTH  seed value.
- deck_clear  in  1  clear used-index mask (deal mode).
- req_valid  in  1  request a new index.
- req_ready  out  1  request can be accepted.
- rnd_valid  out  1  rnd_out holds a result.
- rnd_ready  in  1  consumer takes the result.
- rnd_out  out  OUT_W  issued index.
- rnd_fallback  out  1  result came from the fallback path.
- deck_empty  out  1  all RANGE indices issued (deal mode only; 0 when NO_REPEAT=0).

## Operation
- LFSR: next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}. Advances every cycle regardless of state.
- seed_load takes priority over advancing. seed_in==0 loads SEED instead.
- Candidate c = lfsr[FIELD_LSB +: OUT_W].
- c is acceptable iff c < RANGE and, in deal mode, used[c]==0.
- States:
  - IDLE: req_ready = 1 (0 if deck_empty). On req_valid&req_ready, go to SEARCH and clear tries.
  - SEARCH: each cycle, test c.
    - Accept: rnd_out ← c, rnd_fallback ← 0, go to PRESENT.
    - Reject: tries++.
    - On the MAX_TRIES-th rejection, take the fallback instead: rnd_out ← lowest unused index (deal mode) or c−RANGE if c ≥ RANGE, else c (NO_REPEAT=0); rnd_fallback ← 1; go to PRESENT.
  - PRESENT: rnd_valid = 1. rnd_out and rnd_fallback are held stable. On rnd_ready, go to IDLE.
- used[rnd_out] is set in the cycle the value is captured.
- deck_empty = &used[RANGE-1:0] (registered).
- deck_clear zeroes used next cycle, in any state. If deck_clear coincides with a capture, the clear wins: the value is still delivered but not marked.
- Reset values: lfsr=SEED, state=IDLE, rnd_valid=0, rnd_out=0, rnd_fallback=0, used=0, deck_empty=0, req_ready=1.
- Reset mid-transaction: the transaction is dropped, with no partial output.

## Timing
- Request accepted at edge E0. The candidate is tested in the cycle after E0.
- Earliest rnd_valid: high after edge E1 (1-cycle latency).
- Worst case: rnd_valid after E(MAX_TRIES).
- rnd_valid falls on the edge where rnd_valid&rnd_ready.
- req_ready returns the cycle after that edge; no back-to-back accept in the same cycle as delivery.
- seed_load during SEARCH: the new seed is tested the following cycle, and tries is not reset.
- After the RANGE-th issue, deck_empty rises the next cycle and req_ready stays 0 until deck_clear.

## Structure
- Shared package prng_pkg: DECK_SIZE=52, DEFAULT_SEED=16'hACE1, DEFAULT_TAPS=16'hB400, state enum {IDLE, SEARCH, PRESENT}.
- Sub-module lfsr_core (WIDTH, TAPS, SEED; ports clock, reset, load, load_val, state) holds the shift register and zero-seed guard.
- The lowest-unused priority encoder is a local function in deck_rng.

## Test plan
- Reset, then idle one cycle → lfsr 0xACE1 then 0x59C3; rnd_valid=0, req_ready=1, deck_empty=0.
- Deal mode, rnd_ready tied 1, 52 requests → 52 distinct values covering 0..51, all <52; deck_empty=1, req_ready=0 afterwards; 53rd req_valid ignored.
- After full deck, pulse deck_clear → deck_empty=0 next cycle; a further 52 requests again form a permutation of 0..51.
- MAX_TRIES=1, deal 51 indices, request the 52nd → result equals the single unused index within 1 cycle; rnd_fallback=1 unless the first candidate matched.
- rnd_ready held 0 for 10 cycles in PRESENT → rnd_valid, rnd_out and rnd_fallback stable, req_ready=0; release → rnd_valid falls next edge.
- seed_load with seed_in=0 → lfsr=0xACE1; seed_in=0x1234 → lfsr=0x1234; reset asserted during SEARCH → IDLE, rnd_valid=0, used mask unchanged from reset value 0.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared definitions for the card-game random index generator.
// Contents: deck size, default LFSR seed and tap mask, and the request FSM
// state encoding.
package prng_pkg;

  localparam int          DECK_SIZE    = 52;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    PRESENT = 2'd2
  } state_e;

endpackage : prng_pkg

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with a synchronous seed load.
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous active-high reset, loads SEED
//   load     - load load_val this edge (takes priority over shifting)
//   load_val - seed value; an all-zero value is replaced by SEED
//   state    - current register contents
module lfsr_core
  import prng_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // All-zero is the lock-up state of an XOR LFSR, so it is never loaded.
  always_comb begin
    if (load) begin
      state_d = (load_val == '0) ? SEED : load_val;
    end else begin
      state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule : lfsr_core

// File: rtl/deck_rng.sv
// Request/response random index generator: returns indices in [0, RANGE)
// by rejection sampling a field of a free-running LFSR. In deal mode each
// index is issued at most once until deck_clear; after MAX_TRIES
// consecutive rejections a deterministic fallback value is issued.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   seed_load, seed_in    - reseed the LFSR (zero seed maps to SEED)
//   deck_clear            - forget all issued indices
//   req_valid/req_ready   - request handshake
//   rnd_valid/rnd_ready   - result handshake
//   rnd_out, rnd_fallback - issued index, and whether it came from fallback
//   deck_empty            - every index in the deck has been issued
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for a request (blocked while the deck is empty)
// SEARCH  | testing one LFSR candidate per cycle
// PRESENT | result held on rnd_out until rnd_ready
module deck_rng
  import prng_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = DEFAULT_TAPS,
  parameter logic [WIDTH-1:0] SEED      = DEFAULT_SEED,
  parameter int               OUT_W     = 6,
  parameter int               FIELD_LSB = 5,
  parameter int               RANGE     = DECK_SIZE,
  parameter int               NO_REPEAT = 1,
  parameter int               MAX_TRIES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             deck_clear,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [OUT_W-1:0] rnd_out,
  output logic             rnd_fallback,
  output logic             deck_empty
);

  localparam int NIDX = 2 ** OUT_W;
  localparam int TW   = $clog2(MAX_TRIES + 1);

  logic [WIDTH-1:0] lfsr;
  logic             unused_lfsr;
  logic [OUT_W-1:0] cand;
  logic             cand_ok;
  logic             last_try;
  logic             capture;
  logic [OUT_W-1:0] fb_val;
  logic [OUT_W-1:0] cap_val;

  state_e           state_q;
  logic [TW-1:0]    tries_q;
  logic [NIDX-1:0]  used_q;
  logic [NIDX-1:0]  used_d;
  logic [OUT_W-1:0] rnd_out_q;
  logic             rnd_fallback_q;
  logic             rnd_valid_q;
  logic             deck_empty_q;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr)
  );

  // Only a slice of the LFSR is used as the candidate.
  assign unused_lfsr = ^lfsr;
  assign cand        = lfsr[FIELD_LSB +: OUT_W];

  function automatic logic [OUT_W-1:0] lowest_unused(input logic [NIDX-1:0] used);
    logic [OUT_W-1:0] idx;
    idx = '0;
    for (int i = RANGE - 1; i >= 0; i--) begin
      if (!used[i]) idx = OUT_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    cand_ok  = (int'(cand) < RANGE) && ((NO_REPEAT == 0) || !used_q[cand]);
    last_try = (tries_q == TW'(MAX_TRIES - 1));
    capture  = (state_q == SEARCH) && (cand_ok || last_try);
    if (NO_REPEAT != 0) begin
      fb_val = lowest_unused(used_q);
    end else if (int'(cand) >= RANGE) begin
      // RANGE >= 2^(OUT_W-1) keeps the folded value inside the range.
      fb_val = cand - OUT_W'(RANGE);
    end else begin
      fb_val = cand;
    end
    cap_val = cand_ok ? cand : fb_val;
  end

  // A clear coinciding with a capture wins: the value is delivered unmarked.
  always_comb begin
    used_d = used_q;
    if ((NO_REPEAT != 0) && capture) used_d[cap_val] = 1'b1;
    if (deck_clear) used_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      tries_q        <= '0;
      used_q         <= '0;
      rnd_out_q      <= '0;
      rnd_fallback_q <= 1'b0;
      rnd_valid_q    <= 1'b0;
      deck_empty_q   <= 1'b0;
    end else begin
      used_q       <= used_d;
      deck_empty_q <= (NO_REPEAT != 0) && !deck_clear && (&used_q[RANGE-1:0]);
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            state_q <= SEARCH;
            tries_q <= '0;
          end
        end
        SEARCH: begin
          if (capture) begin
            rnd_out_q      <= cap_val;
            rnd_fallback_q <= !cand_ok;
            rnd_valid_q    <= 1'b1;
            state_q        <= PRESENT;
          end else begin
            tries_q <= tries_q + 1'b1;
          end
        end
        PRESENT: begin
          if (rnd_ready) begin
            rnd_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE) && !deck_empty_q;
  assign rnd_valid    = rnd_valid_q;
  assign rnd_out      = rnd_out_q;
  assign rnd_fallback = rnd_fallback_q;
  assign deck_empty   = deck_empty_q;

endmodule : deck_rng

// File: tb/tb_deck_rng.sv
// Bench for deck_rng: three instances (deal/MAX_TRIES=16, deal/MAX_TRIES=1,
// independent draws/MAX_TRIES=1) share clock, reset and seed inputs; a
// behavioural model predicts every result from the LFSR rule.
module tb_deck_rng;

  logic        clock = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        deck_clear   [3];
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        rnd_valid    [3];
  logic        rnd_ready    [3];
  logic [5:0]  rnd_out      [3];
  logic        rnd_fallback [3];
  logic        deck_empty   [3];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  deck_rng #(.NO_REPEAT(1), .MAX_TRIES(16)) u_d0 (
    .clock(clock), .reset(rst), .seed_load(seed_load), .seed_in(seed_in),
    .deck_clear(deck_clear[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .rnd_valid(rnd_valid[0]), .rnd_ready(rnd_ready[0]), .rnd_out(rnd_out[0]),
    .rnd_fallback(rnd_fallback[0]), .deck_empty(deck_empty[0]));

  deck_rng #(.NO_REPEAT(1), .MAX_TRIES(1)) u_d1 (
    .clock(clock), .reset(rst), .seed_load(seed_load), .seed_in(seed_in),
    .deck_clear(deck_clear[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .rnd_valid(rnd_valid[1]), .rnd_ready(rnd_ready[1]), .rnd_out(rnd_out[1]),
    .rnd_fallback(rnd_fallback[1]), .deck_empty(deck_empty[1]));

  deck_rng #(.NO_REPEAT(0), .MAX_TRIES(1)) u_d2 (
    .clock(clock), .reset(rst), .seed_load(seed_load), .seed_in(seed_in),
    .deck_clear(deck_clear[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .rnd_valid(rnd_valid[2]), .rnd_ready(rnd_ready[2]), .rnd_out(rnd_out[2]),
    .rnd_fallback(rnd_fallback[2]), .deck_empty(deck_empty[2]));

  // ---------------- reference model ----------------
  function automatic int mt(input int k);
    return (k == 0) ? 16 : 1;
  endfunction

  function automatic bit nr(input int k);
    return (k != 2);
  endfunction

  // Fibonacci step: shift left, feed in parity of the tapped bits (15,13,12,10).
  function automatic logic [15:0] nxt(input logic [15:0] v);
    int t;
    t = ((int'(v) << 1) | ($countones(v & 16'hB400) % 2)) & 32'hFFFF;
    return t[15:0];
  endfunction

  logic [15:0] m_lfsr;
  bit   [51:0] m_used [3];
  bit          seen   [64];
  int          last_v;

  always @(posedge clock) begin
    if (rst)            m_lfsr <= 16'hACE1;
    else if (seed_load) m_lfsr <= (seed_in == 16'h0) ? 16'hACE1 : seed_in;
    else                m_lfsr <= nxt(m_lfsr);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_free(input int k);
    for (int i = 0; i < 52; i++) if (!m_used[k][i]) return i;
    return 0;
  endfunction

  // Called just after the accepting edge: m_lfsr is the first candidate.
  task automatic predict(input int k, output int ev, output int ef, output int el);
    logic [15:0] l;
    int c;
    bit ok;
    bit done;
    l = m_lfsr; ev = 0; ef = 0; el = 0; done = 0;
    for (int t = 0; t < mt(k) && !done; t++) begin
      c  = (int'(l) >> 5) & 63;
      ok = (c < 52) && (!nr(k) || !m_used[k][c]);
      if (ok) begin
        ev = c; ef = 0; el = t + 1; done = 1;
      end else if (t == mt(k) - 1) begin
        ef = 1; el = t + 1; done = 1;
        if (nr(k)) ev = lowest_free(k);
        else       ev = (c >= 52) ? c - 52 : c;
      end
      l = nxt(l);
    end
  endtask

  task automatic do_req(input int k, input int stall, input bit clr_at_cap);
    int ev, ef, el, n;
    bit empty;
    @(negedge clock);
    chk("req_ready_before_req", int'(req_ready[k]), 1);
    req_valid[k] = 1'b1;
    @(posedge clock); #1;
    req_valid[k] = 1'b0;
    predict(k, ev, ef, el);
    if (clr_at_cap) deck_clear[k] = 1'b1;
    n = 0;
    while (!rnd_valid[k] && n < 40) begin
      @(posedge clock); #1;
      deck_clear[k] = 1'b0;
      n++;
    end
    chk("latency", n, el);
    chk("rnd_out", int'(rnd_out[k]), ev);
    chk("rnd_fallback", int'(rnd_fallback[k]), ef);
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      chk("hold_valid", int'(rnd_valid[k]), 1);
      chk("hold_out", int'(rnd_out[k]), ev);
      chk("hold_fallback", int'(rnd_fallback[k]), ef);
      chk("hold_req_ready", int'(req_ready[k]), 0);
    end
    rnd_ready[k] = 1'b1;
    @(posedge clock); #1;
    rnd_ready[k] = 1'b0;
    chk("rnd_valid_drop", int'(rnd_valid[k]), 0);
    if (clr_at_cap)  m_used[k] = '0;
    else if (nr(k))  m_used[k][ev] = 1'b1;
    empty = nr(k) && (&m_used[k]);
    chk("deck_empty", int'(deck_empty[k]), int'(empty));
    chk("req_ready_after", int'(req_ready[k]), int'(!empty));
    last_v = ev;
  endtask

  task automatic deal(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      do_req(k, (i == 5) ? 10 : int'($urandom_range(0, 2)), 1'b0);
      chk("deal_in_range", int'(last_v < 52), 1);
      chk("deal_unique", int'(seen[last_v]), 0);
      seen[last_v] = 1'b1;
    end
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
  endtask

  task automatic pulse_clear(input int k);
    @(negedge clock);
    deck_clear[k] = 1'b1;
    @(negedge clock);
    deck_clear[k] = 1'b0;
    m_used[k] = '0;
    chk("clear_deck_empty", int'(deck_empty[k]), 0);
    chk("clear_req_ready", int'(req_ready[k]), 1);
  endtask

  typedef struct {
    logic [15:0] seed;
    logic [15:0] exp_lfsr;
    logic [15:0] exp_next;
  } seed_vec_t;

  seed_vec_t seed_tab [4];

  initial begin
    int cnt, free_idx;
    logic [15:0] a;

    seed_tab[0] = '{16'h0000, 16'hACE1, 16'h59C3};
    seed_tab[1] = '{16'h1234, 16'h1234, 16'h2469};
    seed_tab[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFE};
    seed_tab[3] = '{16'h0001, 16'h0001, 16'h0002};

    rst = 1'b1; seed_load = 1'b0; seed_in = 16'h0;
    for (int k = 0; k < 3; k++) begin
      deck_clear[k] = 1'b0; req_valid[k] = 1'b0; rnd_ready[k] = 1'b0;
      m_used[k] = '0;
    end
    clear_seen();

    // Reset state, then one idle cycle.
    repeat (3) @(negedge clock);
    rst = 1'b0;
    chk("reset_lfsr", int'(u_d0.lfsr), 16'hACE1);
    for (int k = 0; k < 3; k++) begin
      chk("reset_rnd_valid", int'(rnd_valid[k]), 0);
      chk("reset_req_ready", int'(req_ready[k]), 1);
      chk("reset_deck_empty", int'(deck_empty[k]), 0);
      chk("reset_rnd_out", int'(rnd_out[k]), 0);
      chk("reset_fallback", int'(rnd_fallback[k]), 0);
    end
    @(negedge clock);
    chk("idle_lfsr", int'(u_d0.lfsr), 16'h59C3);

    // Reset while searching drops the transaction.
    req_valid[0] = 1'b1;
    @(negedge clock);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    chk("midreset_rnd_valid", int'(rnd_valid[0]), 0);
    chk("midreset_req_ready", int'(req_ready[0]), 1);
    chk("midreset_used", int'(u_d0.used_q == '0), 1);
    chk("midreset_lfsr", int'(u_d0.lfsr), 16'hACE1);
    @(negedge clock);
    chk("midreset_no_output", int'(rnd_valid[0]), 0);

    // Seed-load table.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      seed_in = seed_tab[i].seed; seed_load = 1'b1;
      @(negedge clock);
      seed_load = 1'b0;
      chk("seed_load_value", int'(u_d0.lfsr), int'(seed_tab[i].exp_lfsr));
      @(negedge clock);
      chk("seed_next_value", int'(u_d0.lfsr), int'(seed_tab[i].exp_next));
    end

    @(negedge clock);
    seed_in = 16'($urandom); seed_load = 1'b1;
    @(negedge clock);
    seed_load = 1'b0;

    // Full deal, blocked 53rd request, clear, second deal.
    deal(0, 52);
    cnt = 0;
    for (int i = 0; i < 52; i++) cnt += int'(seen[i]);
    chk("perm1_coverage", cnt, 52);
    @(negedge clock);
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("full_no_accept", int'(rnd_valid[0]), 0);
      chk("full_req_ready", int'(req_ready[0]), 0);
    end
    req_valid[0] = 1'b0;
    pulse_clear(0);
    clear_seen();
    deal(0, 52);
    cnt = 0;
    for (int i = 0; i < 52; i++) cnt += int'(seen[i]);
    chk("perm2_coverage", cnt, 52);

    // MAX_TRIES=1 deal: last index comes from a single test or the fallback.
    clear_seen();
    deal(1, 51);
    free_idx = lowest_free(1);
    deal(1, 1);
    chk("last_is_unused", last_v, free_idx);
    pulse_clear(1);
    // Clear in the capture cycle: value delivered, mask stays empty.
    do_req(1, 0, 1'b1);
    chk("clear_wins_used", int'(u_d1.used_q == '0), 1);

    // Independent draws with folding fallback.
    for (int i = 0; i < 40; i++) begin
      do_req(2, int'($urandom_range(0, 3)), 1'b0);
      chk("indep_in_range", int'(last_v < 52), 1);
    end

    // seed_load during SEARCH: first candidate rejected, reseeded one accepted.
    pulse_clear(0);
    a = 16'h0;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      if (a != 16'h0 && ((int'(nxt(a)) >> 5) & 63) >= 52) break;
    end
    @(negedge clock);
    seed_in = a; seed_load = 1'b1;
    @(negedge clock);
    seed_load = 1'b0;
    chk("seedsearch_req_ready", int'(req_ready[0]), 1);
    req_valid[0] = 1'b1;
    @(negedge clock);
    req_valid[0] = 1'b0;
    seed_in = 16'h00E0; seed_load = 1'b1;
    @(negedge clock);
    seed_load = 1'b0;
    chk("seedsearch_reject", int'(rnd_valid[0]), 0);
    @(negedge clock);
    chk("seedsearch_valid", int'(rnd_valid[0]), 1);
    chk("seedsearch_out", int'(rnd_out[0]), 7);
    chk("seedsearch_fallback", int'(rnd_fallback[0]), 0);
    rnd_ready[0] = 1'b1;
    @(negedge clock);
    rnd_ready[0] = 1'b0;
    chk("seedsearch_drop", int'(rnd_valid[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule : tb_deck_rng
